// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the synchronous instruction memory and hands
// {instr, pc} to decode over a valid/ready handshake with stall and redirect.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        fetch_valid,
  input  logic        decode_ready,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        misalign_d;
  logic [31:0] count_d;
  logic [31:0] redirect_tgt;
  logic        accept;
  logic        stall;

  // Outputs are forced to their idle values while reset is asserted.
  assign fetch_valid  = rst_n & inflight_q & ~redirect_valid;
  assign fetch_pc     = rst_n ? inflight_pc_q : RESET_PC;
  assign fetch_instr  = imem_data;
  assign accept       = fetch_valid & decode_ready;
  assign stall        = inflight_q & ~decode_ready & ~redirect_valid;
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    misalign_d    = 1'b0;
    count_d       = fetch_count;
    imem_addr     = pc_q;
    if (accept) count_d = fetch_count + 32'd1;
    if (redirect_valid) begin
      imem_addr     = redirect_tgt;
      inflight_d    = 1'b1;
      inflight_pc_d = redirect_tgt;
      pc_d          = redirect_tgt + 32'd4;
      misalign_d    = |redirect_pc[1:0];
    end else if (stall) begin
      // Re-read the held address so imem_data stays stable across the stall.
      imem_addr = inflight_pc_q;
    end else if (fetch_en && (!inflight_q || accept)) begin
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
      pc_d          = pc_q + 32'd4;
    end else begin
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
      misalign_err  <= 1'b0;
      fetch_count   <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      misalign_err  <= misalign_d;
      fetch_count   <= count_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table for the corner cases,
// then randomized traffic against a behavioural model of the fetch stream.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data = 32'd0;
  logic        fetch_valid;
  logic        decode_ready;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int n_vec  = 0;
  int n_miss = 0;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .fetch_valid(fetch_valid), .decode_ready(decode_ready),
    .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Synchronous instruction memory with a one-cycle registered read.
  always @(posedge clk) imem_data <= mem_word(imem_addr);

  typedef struct {
    logic        rst_n, en, rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_pc, exp_addr;
    logic        exp_err;
    logic [31:0] exp_count;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, e, v, input logic [31:0] p, input logic d,
                              input logic ev, input logic [31:0] epc, ea,
                              input logic ee, input logic [31:0] ec);
    vec_t t;
    t.rst_n = r; t.en = e; t.rv = v; t.rpc = p; t.rdy = d;
    t.exp_valid = ev; t.exp_pc = epc; t.exp_addr = ea; t.exp_err = ee; t.exp_count = ec;
    return t;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic r, e, v, input logic [31:0] p, input logic d);
    @(posedge clk);
    #1;
    rst_n = r; fetch_en = e; redirect_valid = v; redirect_pc = p; decode_ready = d;
    @(negedge clk);
  endtask

  task automatic check_all(input string tag, input logic ev, input logic [31:0] epc, ea,
                           input logic ee, input logic [31:0] ec);
    check_output({tag, " valid"}, {31'd0, fetch_valid}, {31'd0, ev});
    check_output({tag, " pc"}, fetch_pc, epc);
    check_output({tag, " addr"}, imem_addr, ea);
    check_output({tag, " err"}, {31'd0, misalign_err}, {31'd0, ee});
    check_output({tag, " count"}, fetch_count, ec);
    if (ev) check_output({tag, " instr"}, fetch_instr, mem_word(epc));
  endtask

  // Behavioural model: the word in flight, the next address and the counters.
  logic        m_busy;
  logic [31:0] m_cur, m_next, m_cnt;
  logic        m_err;

  initial begin
    logic        r, e, v, d, ev;
    logic [31:0] p, ea, epc;

    rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'd0; decode_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset, streaming, stall, redirect, misalign, fetch_en gap, reset mid-stall, wrap.
    tbl.push_back(mk(0,1,0,32'h0,1, 0,32'h00,32'h00,0,0));
    tbl.push_back(mk(1,1,0,32'h0,1, 0,32'h00,32'h00,0,0));
    tbl.push_back(mk(1,1,0,32'h0,1, 1,32'h00,32'h04,0,0));
    tbl.push_back(mk(1,1,0,32'h0,1, 1,32'h04,32'h08,0,1));
    tbl.push_back(mk(1,1,0,32'h0,0, 1,32'h08,32'h08,0,2));
    tbl.push_back(mk(1,1,0,32'h0,0, 1,32'h08,32'h08,0,2));
    tbl.push_back(mk(1,1,0,32'h0,0, 1,32'h08,32'h08,0,2));
    tbl.push_back(mk(1,1,0,32'h0,1, 1,32'h08,32'h0C,0,2));
    tbl.push_back(mk(1,1,0,32'h0,1, 1,32'h0C,32'h10,0,3));
    tbl.push_back(mk(1,1,1,32'h40,1, 0,32'h10,32'h40,0,4));
    tbl.push_back(mk(1,1,0,32'h0,1, 1,32'h40,32'h44,0,4));
    tbl.push_back(mk(1,1,0,32'h0,1, 1,32'h44,32'h48,0,5));
    tbl.push_back(mk(1,1,1,32'h42,1, 0,32'h48,32'h40,0,6));
    tbl.push_back(mk(1,1,0,32'h0,1, 1,32'h40,32'h44,1,6));
    tbl.push_back(mk(1,1,0,32'h0,1, 1,32'h44,32'h48,0,7));
    tbl.push_back(mk(1,1,1,32'h20,1, 0,32'h48,32'h20,0,8));
    tbl.push_back(mk(1,0,0,32'h0,1, 1,32'h20,32'h24,0,8));
    tbl.push_back(mk(1,0,0,32'h0,1, 0,32'h20,32'h24,0,9));
    tbl.push_back(mk(1,1,0,32'h0,1, 0,32'h20,32'h24,0,9));
    tbl.push_back(mk(1,1,0,32'h0,1, 1,32'h24,32'h28,0,9));
    tbl.push_back(mk(1,1,0,32'h0,1, 1,32'h28,32'h2C,0,10));
    tbl.push_back(mk(1,1,0,32'h0,1, 1,32'h2C,32'h30,0,11));
    tbl.push_back(mk(1,1,0,32'h0,0, 1,32'h30,32'h30,0,12));
    tbl.push_back(mk(0,1,0,32'h0,0, 0,32'h00,32'h30,0,12));
    tbl.push_back(mk(1,1,0,32'h0,1, 0,32'h00,32'h00,0,0));
    tbl.push_back(mk(1,1,0,32'h0,1, 1,32'h00,32'h04,0,0));
    tbl.push_back(mk(1,1,1,32'hFFFF_FFFC,1, 0,32'h04,32'hFFFF_FFFC,0,1));
    tbl.push_back(mk(1,1,0,32'h0,1, 1,32'hFFFF_FFFC,32'h00,0,1));
    tbl.push_back(mk(1,1,0,32'h0,1, 1,32'h00,32'h04,0,2));

    foreach (tbl[i]) begin
      apply_stimulus(tbl[i].rst_n, tbl[i].en, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      check_all($sformatf("dir%0d", i), tbl[i].exp_valid, tbl[i].exp_pc,
                tbl[i].exp_addr, tbl[i].exp_err, tbl[i].exp_count);
    end

    // Random phase starts from a clean reset so the model and DUT agree.
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    m_busy = 1'b0; m_cur = 32'd0; m_next = 32'd0; m_cnt = 32'd0; m_err = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 59) != 0);
      e = ($urandom_range(0, 7) != 0);
      v = ($urandom_range(0, 7) == 0);
      d = ($urandom_range(0, 3) != 0);
      p = ($urandom_range(0, 3) == 0) ? $urandom : {24'd0, 8'($urandom)};
      apply_stimulus(r, e, v, p, d);

      ev  = r & m_busy & ~v;
      epc = r ? m_cur : 32'd0;
      if (v)                ea = {p[31:2], 2'b00};
      else if (m_busy & ~d) ea = m_cur;
      else                  ea = m_next;
      check_all($sformatf("rnd%0d", n), ev, epc, ea, m_err, m_cnt);

      if (!r) begin
        m_busy = 1'b0; m_cur = 32'd0; m_next = 32'd0; m_cnt = 32'd0; m_err = 1'b0;
      end else if (v) begin
        m_busy = 1'b1; m_cur = {p[31:2], 2'b00}; m_next = m_cur + 32'd4; m_err = |p[1:0];
      end else begin
        m_err = 1'b0;
        if (m_busy && d) m_cnt = m_cnt + 32'd1;
        if (m_busy && !d) begin
          // decode is holding the current word
        end else if (e) begin
          m_busy = 1'b1; m_cur = m_next; m_next = m_next + 32'd4;
        end else begin
          m_busy = 1'b0;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
